// File: rtl/cpu_top.sv
// cpu_top: Mini SRC datapath core.
// Holds a 16x32 general-purpose register file and the special registers
// HI, LO, ZHI, ZLO, PC, MDR, IR and MAR. Any one of them is loaded from
// data_in per cycle, and any one of them is muxed onto bus_out.
// Optional build macro: CPU_TOP_R0_ZERO_EN makes R0 a hardwired zero.
module cpu_top (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [3:0]  addr_in,
    input  logic [3:0]  addr_out,
    input  logic [31:0] data_in,
    input  logic [4:0]  reg_out_select,
    output logic [31:0] bus_out
);

    // Special register slots, indexed by the low three select bits
    // when the select is in the 0x10-0x17 window.
    localparam logic [2:0] SPR_HI  = 3'd0;
    localparam logic [2:0] SPR_LO  = 3'd1;
    localparam logic [2:0] SPR_ZHI = 3'd2;
    localparam logic [2:0] SPR_ZLO = 3'd3;
    localparam logic [2:0] SPR_PC  = 3'd4;
    localparam logic [2:0] SPR_MDR = 3'd5;
    localparam logic [2:0] SPR_IR  = 3'd6;
    localparam logic [2:0] SPR_MAR = 3'd7;

    logic [31:0] gpr [16];
    logic [31:0] spr [8];

    // Select decode shared by the write path and the bus mux.
    logic        sel_gpr;
    logic        sel_spr;
    logic [2:0]  spr_idx;
    logic        gpr_write_ok;

    assign sel_gpr = ~reg_out_select[4];
    assign sel_spr = reg_out_select[4] & ~reg_out_select[3];
    assign spr_idx = reg_out_select[2:0];

`ifdef CPU_TOP_R0_ZERO_EN
    assign gpr_write_ok = (addr_in != 4'd0);
`else
    assign gpr_write_ok = 1'b1;
`endif

    // Register file update: reset wins over load, and at most one
    // register takes data_in on a load edge (none for 0x18-0x1F).
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                gpr[i] <= '0;
            end
            for (int j = 0; j < 8; j++) begin
                spr[j] <= '0;
            end
        end else if (load) begin
            if (sel_gpr) begin
                if (gpr_write_ok) begin
                    gpr[addr_in] <= data_in;
                end
            end else if (sel_spr) begin
                spr[spr_idx] <= data_in;
            end
        end
    end

    // Bus source mux: GPR window reads by addr_out, special window by
    // select code, reserved codes drive zero.
    always_comb begin
        bus_out = '0;
        if (sel_gpr) begin
`ifdef CPU_TOP_R0_ZERO_EN
            if (addr_out != 4'd0) begin
                bus_out = gpr[addr_out];
            end
`else
            bus_out = gpr[addr_out];
`endif
        end else if (sel_spr) begin
            unique case (spr_idx)
                SPR_HI:  bus_out = spr[SPR_HI];
                SPR_LO:  bus_out = spr[SPR_LO];
                SPR_ZHI: bus_out = spr[SPR_ZHI];
                SPR_ZLO: bus_out = spr[SPR_ZLO];
                SPR_PC:  bus_out = spr[SPR_PC];
                SPR_MDR: bus_out = spr[SPR_MDR];
                SPR_IR:  bus_out = spr[SPR_IR];
                SPR_MAR: bus_out = spr[SPR_MAR];
                default: bus_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: directed and randomized checks of cpu_top against a
// behavioural register model. Honors CPU_TOP_R0_ZERO_EN when defined.
module tb_cpu_top;

    logic        clk;
    logic        reset;
    logic        load;
    logic [3:0]  addr_in;
    logic [3:0]  addr_out;
    logic [31:0] data_in;
    logic [4:0]  reg_out_select;
    logic [31:0] bus_out;

    int checks;
    int passes;

    // Reference model: named register storage, updated with plain rules.
    logic [31:0] m_gpr [16];
    logic [31:0] m_spr [8];

`ifdef CPU_TOP_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    cpu_top dut (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .addr_in        (addr_in),
        .addr_out       (addr_out),
        .data_in        (data_in),
        .reg_out_select (reg_out_select),
        .bus_out        (bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // What the bus should show for a given select/address.
    function automatic logic [31:0] expected_bus(input int sel, input int a);
        if (sel < 16) begin
            if (R0_ZERO && a == 0) return 32'h0;
            return m_gpr[a];
        end
        if (sel < 24) return m_spr[sel - 16];
        return 32'h0;
    endfunction

    // Apply one clock edge's worth of register effects to the model.
    task automatic model_edge(input bit rst, input bit ld, input int sel,
                              input int ain, input logic [31:0] d);
        if (rst) begin
            for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
            for (int i = 0; i < 8; i++)  m_spr[i] = 32'h0;
        end else if (ld) begin
            if (sel < 16) begin
                if (!(R0_ZERO && ain == 0)) m_gpr[ain] = d;
            end else if (sel < 24) begin
                m_spr[sel - 16] = d;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp);
        checks++;
        assert (bus_out === exp) passes++;
        else $error("[TB] FAIL %s: observed=%h expected=%h (sel=%h addr_out=%0d)",
                    tag, bus_out, exp, reg_out_select, addr_out);
    endtask

    // Drive inputs after a falling edge, take the rising edge, update the model.
    task automatic applyStimulus(input bit rst, input bit ld, input int sel,
                                 input int ain, input logic [31:0] d);
        @(negedge clk);
        reset          = rst;
        load           = ld;
        reg_out_select = 5'(sel);
        addr_in        = 4'(ain);
        data_in        = d;
        @(posedge clk);
        model_edge(rst, ld, sel, ain, d);
        #1;
        reset = 1'b0;
        load  = 1'b0;
    endtask

    task automatic read_check(input string tag, input int sel, input int a);
        reg_out_select = 5'(sel);
        addr_out       = 4'(a);
        #1;
        checkOutput(tag, expected_bus(sel, a));
    endtask

    task automatic sweep_all(input string tag);
        for (int s = 0; s < 32; s++) begin
            for (int a = 0; a < 16; a++) begin
                read_check(tag, s, a);
            end
        end
    endtask

    initial begin
        logic [31:0] exp_r0;
        bit          r_rst;
        bit          r_ld;
        int          r_sel;
        int          r_ain;
        int          r_aout;
        logic [31:0] r_d;

        checks = 0;
        passes = 0;
        reset = 1'b0;
        load = 1'b0;
        addr_in = '0;
        addr_out = '0;
        data_in = '0;
        reg_out_select = '0;
        for (int i = 0; i < 16; i++) m_gpr[i] = 32'h0;
        for (int i = 0; i < 8; i++)  m_spr[i] = 32'h0;

        // Reset: every select/address must read zero.
        applyStimulus(1'b1, 1'b0, 0, 0, 32'h0);
        sweep_all("reset_sweep");

        // GPR write/read.
        applyStimulus(1'b0, 1'b1, 0, 0, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 0, 1, 32'hFACECAFE);
        exp_r0 = R0_ZERO ? 32'h0 : 32'hDEADBEEF;
        reg_out_select = 5'h00; addr_out = 4'd0; #1;
        checkOutput("gpr_r0", exp_r0);
        reg_out_select = 5'h07; addr_out = 4'd1; #1;
        checkOutput("gpr_r1", 32'hFACECAFE);
        for (int a = 2; a < 16; a++) begin
            reg_out_select = 5'h00; addr_out = 4'(a); #1;
            checkOutput("gpr_rest", 32'h0);
        end

        // Special registers.
        applyStimulus(1'b0, 1'b1, 5'h14, 0, 32'h12345678);
        applyStimulus(1'b0, 1'b1, 5'h16, 0, 32'hCAFEBABE);
        reg_out_select = 5'h14; #1;
        checkOutput("spr_pc", 32'h12345678);
        reg_out_select = 5'h16; #1;
        checkOutput("spr_ir", 32'hCAFEBABE);
        reg_out_select = 5'h00; addr_out = 4'd0; #1;
        checkOutput("spr_r0_kept", exp_r0);
        sweep_all("spr_sweep");

        // Load gating: load low leaves everything alone.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, k * 5, k, 32'hFFFFFFFF);
        end
        sweep_all("noload_sweep");

        // Reserved select with load high: no write, bus zero.
        applyStimulus(1'b0, 1'b1, 5'h1A, 3, 32'h0BADF00D);
        reg_out_select = 5'h1A; #1;
        checkOutput("reserved_bus", 32'h0);
        sweep_all("reserved_sweep");

        // Same-cycle read shows the old value, new value right after the edge.
        @(negedge clk);
        load = 1'b1; reg_out_select = 5'h00; addr_in = 4'd5; addr_out = 4'd5;
        data_in = 32'h55AA33CC;
        #1;
        checkOutput("rdw_old", expected_bus(0, 5));
        @(posedge clk);
        model_edge(1'b0, 1'b1, 0, 5, 32'h55AA33CC);
        #1;
        load = 1'b0;
        checkOutput("rdw_new", 32'h55AA33CC);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            r_rst  = ($urandom_range(0, 40) == 0);
            r_ld   = ($urandom_range(0, 3) != 0);
            r_sel  = int'($urandom_range(0, 31));
            r_ain  = int'($urandom_range(0, 15));
            r_aout = int'($urandom_range(0, 15));
            r_d    = $urandom;
            @(negedge clk);
            reset = r_rst; load = r_ld; reg_out_select = 5'(r_sel);
            addr_in = 4'(r_ain); addr_out = 4'(r_aout); data_in = r_d;
            #1;
            checkOutput("rand_pre", expected_bus(r_sel, r_aout));
            @(posedge clk);
            model_edge(r_rst, r_ld, r_sel, r_ain, r_d);
            #1;
            reset = 1'b0; load = 1'b0;
            checkOutput("rand_post", expected_bus(r_sel, r_aout));
        end
        sweep_all("rand_sweep");

        // Make sure PC holds something nonzero before the priority test.
        applyStimulus(1'b0, 1'b1, 5'h14, 0, 32'h13579BDF);
        reg_out_select = 5'h14; #1;
        checkOutput("pc_before_prio", 32'h13579BDF);

        // Reset priority over a simultaneous load.
        applyStimulus(1'b1, 1'b1, 5'h14, 0, 32'hAAAA5555);
        reg_out_select = 5'h14; #1;
        checkOutput("prio_pc", 32'h0);
        sweep_all("prio_sweep");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
